// File: rtl/multi_warp_scoreboard_pkg.sv
// Shared types and sizing for the dispatcher's per-warp register scoreboard.
package dispatcher_pkg;

  localparam int NUM_WARPS    = 8;
  localparam int NUM_REGS     = 32;
  localparam int SB_CNT_W     = 2;
  localparam int NUM_WB_PORTS = 2;
  localparam int WARP_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  typedef logic [WARP_W-1:0]   warp_id_t;
  typedef logic [NUM_REGS-1:0] reg_map_t;

  // Extended by one bit so the compare stays meaningful when NUM_WARPS is a power of two.
  function automatic logic warp_in_range(input warp_id_t w);
    return {1'b0, w} < (WARP_W+1)'(NUM_WARPS);
  endfunction

endpackage

// File: rtl/multi_warp_scoreboard_if.sv
// Dispatcher <-> scoreboard bundle: collision query, reservation, write-back and flush.
interface multi_warp_scoreboard_if;
  import dispatcher_pkg::*;

  logic                              rd_valid;
  warp_id_t                          rd_warp;
  reg_map_t                          rd_map;
  logic                              collision;

  logic                              rsv_valid;
  warp_id_t                          rsv_warp;
  reg_map_t                          rsv_map;
  logic                              rsv_ready;

  logic     [NUM_WB_PORTS-1:0]       wb_valid;
  warp_id_t [NUM_WB_PORTS-1:0]       wb_warp;
  reg_map_t [NUM_WB_PORTS-1:0]       wb_map;

  logic                              flush_valid;
  warp_id_t                          flush_warp;

  logic     [NUM_WARPS-1:0]          warp_busy;
  logic                              underflow_err;

  modport master (
    output rd_valid, rd_warp, rd_map,
    output rsv_valid, rsv_warp, rsv_map,
    output wb_valid, wb_warp, wb_map,
    output flush_valid, flush_warp,
    input  collision, rsv_ready, warp_busy, underflow_err
  );

  modport slave (
    input  rd_valid, rd_warp, rd_map,
    input  rsv_valid, rsv_warp, rsv_map,
    input  wb_valid, wb_warp, wb_map,
    input  flush_valid, flush_warp,
    output collision, rsv_ready, warp_busy, underflow_err
  );

endinterface

// File: rtl/multi_warp_scoreboard_sb_counter.sv
// One pending-write counter: +inc, -dec per cycle, clamps at zero and flags the underflow.
module sb_counter #(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec,
  input  logic             clr,
  output logic             nonzero,
  output logic             is_max,
  output logic             underflow
);

  localparam int SUM_W = CNT_W + DEC_W + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum;
  logic             neg;

  // Two's-complement at the widened width; the MSB is the sign.
  assign sum = SUM_W'(cnt_q) + SUM_W'(inc) - SUM_W'(dec);
  assign neg = sum[SUM_W-1];

  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (neg) begin
      cnt_d     = '0;
      underflow = 1'b1;
    end else begin
      cnt_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign nonzero = |cnt_q;
  assign is_max  = &cnt_q;

endmodule

// File: rtl/multi_warp_scoreboard.sv
// Per-warp register scoreboard: counts outstanding writes per register and answers issue/reserve queries.
module multi_warp_scoreboard
  import dispatcher_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input logic                    clk,
  input logic                    rst_n,
  multi_warp_scoreboard_if.slave sb
);

  localparam int DEC_W = $clog2(NUM_WB_PORTS + 1);

  logic                                 rsv_acc;
  logic [NUM_WARPS-1:0][NUM_REGS-1:0]   inc;
  logic [DEC_W-1:0]                     dec [NUM_WARPS][NUM_REGS];
  logic [NUM_WARPS-1:0]                 clr;
  reg_map_t [NUM_WARPS-1:0]             nz_map;
  reg_map_t [NUM_WARPS-1:0]             max_map;
  logic [NUM_WARPS-1:0][NUM_REGS-1:0]   uf;
  logic                                 underflow_err_q;

  assign rsv_acc = sb.rsv_valid && sb.rsv_ready;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      clr[w] = sb.flush_valid && (sb.flush_warp == WARP_W'(w));
      for (int r = 0; r < NUM_REGS; r++) begin
        inc[w][r] = rsv_acc && (sb.rsv_warp == WARP_W'(w)) && sb.rsv_map[r];
      end
    end
  end

  // Port popcount per counter: each matching write-back releases one outstanding write.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        dec[w][r] = '0;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
          if (sb.wb_valid[p] && (sb.wb_warp[p] == WARP_W'(w)) && sb.wb_map[p][r])
            dec[w][r] = dec[w][r] + DEC_W'(1);
        end
      end
    end
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      sb_counter #(
        .CNT_W (CNT_W),
        .DEC_W (DEC_W)
      ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (inc[w][r]),
        .dec       (dec[w][r]),
        .clr       (clr[w]),
        .nonzero   (nz_map[w][r]),
        .is_max    (max_map[w][r]),
        .underflow (uf[w][r])
      );
    end
    assign sb.warp_busy[w] = |nz_map[w];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) underflow_err_q <= 1'b0;
    else        underflow_err_q <= underflow_err_q | (|uf);
  end

  assign sb.underflow_err = underflow_err_q;

  // Both queries look only at registered counts; same-cycle traffic is not bypassed.
  always_comb begin
    sb.collision = 1'b0;
    if (sb.rd_valid && warp_in_range(sb.rd_warp))
      sb.collision = |(sb.rd_map & nz_map[sb.rd_warp]);
  end

  always_comb begin
    sb.rsv_ready = 1'b0;
    if (warp_in_range(sb.rsv_warp)) begin
      sb.rsv_ready = !(|(sb.rsv_map & max_map[sb.rsv_warp])) &&
                     !(sb.flush_valid && (sb.flush_warp == sb.rsv_warp));
    end
  end

endmodule
